// File: rtl/chess_display_pkg.sv
// Shared encodings for the chess VGA renderer: piece codes, RGB332 colours and the piece palette.
// Colours are packed {r[2:0], g[2:0], b[1:0]}.
package chess_display_pkg;

  typedef enum logic [2:0] {
    PIECE_EMPTY   = 3'd0,
    PIECE_PAWN    = 3'd1,
    PIECE_KNIGHT  = 3'd2,
    PIECE_BISHOP  = 3'd3,
    PIECE_ROOK    = 3'd4,
    PIECE_QUEEN   = 3'd5,
    PIECE_KING    = 3'd6,
    PIECE_INVALID = 3'd7
  } pieceType_e;

  typedef logic [7:0] rgb332_t;

  localparam rgb332_t COL_BLANK      = 8'h00;
  localparam rgb332_t COL_LIGHT      = 8'hF9;
  localparam rgb332_t COL_DARK       = 8'h88;
  localparam rgb332_t COL_BACKGROUND = 8'h01;
  localparam rgb332_t COL_CURSOR     = 8'hFC;
  localparam rgb332_t COL_SELECT     = 8'h1C;

  // Row 0 is white, row 1 is black; entries 0 and 7 are never displayed.
  localparam rgb332_t PIECE_PALETTE [2][8] = '{
    '{8'h00, 8'hFF, 8'hFE, 8'hFB, 8'hDF, 8'hFD, 8'hFA, 8'h00},
    '{8'h00, 8'h25, 8'h45, 8'h29, 8'h48, 8'h61, 8'h22, 8'h00}
  };

  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chess_vga_renderer_if.sv
// Game-state inputs and VGA pin outputs of the chess renderer.
// master = game-state top side, slave = renderer side.
interface chess_vga_renderer_if;

  logic [255:0] board;
  logic [5:0]   cursorAddr;
  logic [5:0]   selectAddr;
  logic         selectEn;

  logic         hsync;
  logic         vsync;
  logic [2:0]   r;
  logic [2:0]   g;
  logic [1:0]   b;
  logic         frameStart;

  modport master (
    output board, cursorAddr, selectAddr, selectEn,
    input  hsync, vsync, r, g, b, frameStart
  );

  modport slave (
    input  board, cursorAddr, selectAddr, selectEn,
    output hsync, vsync, r, g, b, frameStart
  );

endinterface

// File: rtl/vga_timing_gen.sv
// Beam timing: pixel-enable divider plus h/v counters with active and raw sync flags.
// Sync outputs are high while inside the sync pulse; polarity is applied by the renderer.
module vga_timing_gen
  import chess_display_pkg::*;
#(
  parameter int PIX_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = cntWidth(H_TOTAL),
  localparam int VW      = cntWidth(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          pixEn_o,
  output logic [HW-1:0] h_o,
  output logic [VW-1:0] v_o,
  output logic          active_o,
  output logic          hsync_o,
  output logic          vsync_o
);

  localparam int DW = cntWidth(PIX_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

  logic [DW-1:0] divCnt_q, divCnt_d;
  logic [HW-1:0] hCnt_q, hCnt_d;
  logic [VW-1:0] vCnt_q, vCnt_d;

  assign pixEn_o = (divCnt_q == DIV_LAST);

  always_comb begin
    divCnt_d = divCnt_q + 1'b1;
    if (divCnt_q == DIV_LAST) begin
      divCnt_d = '0;
    end
  end

  always_comb begin
    hCnt_d = hCnt_q;
    vCnt_d = vCnt_q;
    if (pixEn_o) begin
      if (hCnt_q == H_LAST) begin
        hCnt_d = '0;
        vCnt_d = (vCnt_q == V_LAST) ? '0 : vCnt_q + 1'b1;
      end else begin
        hCnt_d = hCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      divCnt_q <= '0;
      hCnt_q   <= '0;
      vCnt_q   <= '0;
    end else begin
      divCnt_q <= divCnt_d;
      hCnt_q   <= hCnt_d;
      vCnt_q   <= vCnt_d;
    end
  end

  assign h_o      = hCnt_q;
  assign v_o      = vCnt_q;
  assign active_o = (int'(hCnt_q) < H_ACTIVE) && (int'(vCnt_q) < V_ACTIVE);
  assign hsync_o  = (int'(hCnt_q) >= H_ACTIVE + H_FP) &&
                    (int'(hCnt_q) <  H_ACTIVE + H_FP + H_SYNC);
  assign vsync_o  = (int'(vCnt_q) >= V_ACTIVE + V_FP) &&
                    (int'(vCnt_q) <  V_ACTIVE + V_FP + V_SYNC);

endmodule

// File: rtl/chess_vga_renderer.sv
// Chess board VGA renderer: per-frame snapshot of game state, divider-free board geometry
// and a two-stage pixel pipeline with sync delayed to match the colour data.
module chess_vga_renderer
  import chess_display_pkg::*;
#(
  parameter int PIX_DIV   = 4,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0,
  parameter int SQUARE_PX = 56,
  parameter int BOARD_X0  = 96,
  parameter int BOARD_Y0  = 16,
  parameter int INSET     = 12,
  parameter int BORDER_W  = 3
) (
  input logic                 clk_i,
  input logic                 rst_i,
  chess_vga_renderer_if.slave vga
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = cntWidth(H_TOTAL);
  localparam int VW       = cntWidth(V_TOTAL);
  localparam int BOARD_PX = 8 * SQUARE_PX;
  localparam int OW       = cntWidth(SQUARE_PX);
  localparam logic [OW-1:0] OFF_LAST = OW'(SQUARE_PX - 1);

  logic          pixEn;
  logic          active;
  logic          hsRaw;
  logic          vsRaw;
  logic [HW-1:0] hPos;
  logic [VW-1:0] vPos;

  vga_timing_gen #(
    .PIX_DIV  (PIX_DIV),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) uTiming (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .pixEn_o  (pixEn),
    .h_o      (hPos),
    .v_o      (vPos),
    .active_o (active),
    .hsync_o  (hsRaw),
    .vsync_o  (vsRaw)
  );

  // Snapshot at the first pixel of vertical blanking so the next frame never tears.
  logic         snapEvent;
  logic [255:0] boardSh_q;
  logic [5:0]   cursorSh_q;
  logic [5:0]   selectSh_q;
  logic         selectEnSh_q;
  logic         frameStart_q;

  assign snapEvent = pixEn && (hPos == '0) && (int'(vPos) == V_ACTIVE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      boardSh_q    <= '0;
      cursorSh_q   <= '0;
      selectSh_q   <= '0;
      selectEnSh_q <= 1'b0;
      frameStart_q <= 1'b0;
    end else begin
      frameStart_q <= snapEvent;
      if (snapEvent) begin
        boardSh_q    <= vga.board;
        cursorSh_q   <= vga.cursorAddr;
        selectSh_q   <= vga.selectAddr;
        selectEnSh_q <= vga.selectEn;
      end
    end
  end

  logic          active_q, hs1_q, vs1_q;
  logic          inX_q, inX_d, inY_q, inY_d;
  logic [OW-1:0] xOff_q, xOff_d, yOff_q, yOff_d;
  logic [2:0]    col_q, col_d, row_q, row_d;

  // Offsets step from the previous pixel's values; vertical ones only move at line start.
  always_comb begin
    inX_d  = (int'(hPos) >= BOARD_X0) && (int'(hPos) < BOARD_X0 + BOARD_PX);
    inY_d  = (int'(vPos) >= BOARD_Y0) && (int'(vPos) < BOARD_Y0 + BOARD_PX);
    xOff_d = '0;
    col_d  = '0;
    if (inX_d && int'(hPos) != BOARD_X0) begin
      if (xOff_q == OFF_LAST) begin
        col_d = col_q + 1'b1;
      end else begin
        xOff_d = xOff_q + 1'b1;
        col_d  = col_q;
      end
    end
    yOff_d = yOff_q;
    row_d  = row_q;
    if (hPos == '0) begin
      yOff_d = '0;
      row_d  = '0;
      if (inY_d && int'(vPos) != BOARD_Y0) begin
        if (yOff_q == OFF_LAST) begin
          row_d = row_q + 1'b1;
        end else begin
          yOff_d = yOff_q + 1'b1;
          row_d  = row_q;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      hs1_q    <= 1'b0;
      vs1_q    <= 1'b0;
      inX_q    <= 1'b0;
      inY_q    <= 1'b0;
      xOff_q   <= '0;
      yOff_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
    end else if (pixEn) begin
      active_q <= active;
      hs1_q    <= hsRaw;
      vs1_q    <= vsRaw;
      inX_q    <= inX_d;
      inY_q    <= inY_d;
      xOff_q   <= xOff_d;
      yOff_q   <= yOff_d;
      col_q    <= col_d;
      row_q    <= row_d;
    end
  end

  logic [5:0] square;
  logic [3:0] piece;
  logic       onBorder;
  logic       inPiece;
  rgb332_t    pixel_d, pixel_q;
  logic       hsync_q, vsync_q;

  always_comb begin
    square   = {row_q, col_q};
    piece    = boardSh_q[{square, 2'b00} +: 4];
    onBorder = (int'(xOff_q) < BORDER_W) || (int'(xOff_q) >= SQUARE_PX - BORDER_W) ||
               (int'(yOff_q) < BORDER_W) || (int'(yOff_q) >= SQUARE_PX - BORDER_W);
    inPiece  = (int'(xOff_q) >= INSET) && (int'(xOff_q) < SQUARE_PX - INSET) &&
               (int'(yOff_q) >= INSET) && (int'(yOff_q) < SQUARE_PX - INSET);
    pixel_d  = COL_BLANK;
    if (!active_q) begin
      pixel_d = COL_BLANK;
    end else if (!(inX_q && inY_q)) begin
      pixel_d = COL_BACKGROUND;
    end else if (square == cursorSh_q && onBorder) begin
      pixel_d = COL_CURSOR;
    end else if (selectEnSh_q && square == selectSh_q && onBorder) begin
      pixel_d = COL_SELECT;
    end else if (piece[2:0] != PIECE_EMPTY && piece[2:0] != PIECE_INVALID && inPiece) begin
      pixel_d = PIECE_PALETTE[piece[3]][piece[2:0]];
    end else if (row_q[0] ^ col_q[0]) begin
      pixel_d = COL_DARK;
    end else begin
      pixel_d = COL_LIGHT;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pixel_q <= COL_BLANK;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
    end else if (pixEn) begin
      pixel_q <= pixel_d;
      hsync_q <= hs1_q ? SYNC_POL : ~SYNC_POL;
      vsync_q <= vs1_q ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign vga.r          = pixel_q[7:5];
  assign vga.g          = pixel_q[4:2];
  assign vga.b          = pixel_q[1:0];
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.frameStart = frameStart_q;

endmodule

// File: tb/tb_chess_vga_renderer.sv
// Bench for chess_vga_renderer on a shrunken raster so several whole frames fit a short run.
// Every output is predicted each CLK from beam coordinates and the board drawing rules.
module tb_chess_vga_renderer;
  import chess_display_pkg::*;

  localparam int P   = 2;
  localparam int HA  = 52, HFP = 4, HSW = 6, HBP = 6;
  localparam int VA  = 44, VFP = 2, VSW = 2, VBP = 3;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam bit POL = 1'b0;
  localparam int S   = 5, X0 = 6, Y0 = 2, INS = 2, BW = 1;
  localparam int FRAME_CYC = HT * VT * P;
  localparam logic [10:0] RESET_OUT = {1'b0, ~POL, ~POL, 8'h00};

  logic clk = 1'b0;
  logic rst = 1'b0;

  chess_vga_renderer_if vgaIf();

  chess_vga_renderer #(
    .PIX_DIV (P),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SYNC_POL(POL),
    .SQUARE_PX(S), .BOARD_X0(X0), .BOARD_Y0(Y0),
    .INSET(INS), .BORDER_W(BW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .vga  (vgaIf)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;
  int edgeCount  = 0;

  logic [255:0] drvBoard;
  logic [5:0]   drvCur, drvSel;
  logic         drvEn;
  logic [255:0] shBoard;
  logic [5:0]   shCur, shSel;
  logic         shEn;

  task automatic applyStimulus(input logic [255:0] board, input logic [5:0] cur,
                               input logic [5:0] sel, input logic en);
    drvBoard = board;
    drvCur   = cur;
    drvSel   = sel;
    drvEn    = en;
    vgaIf.board      = board;
    vgaIf.cursorAddr = cur;
    vgaIf.selectAddr = sel;
    vgaIf.selectEn   = en;
  endtask

  task automatic checkOutput(input string tag, input logic [10:0] expected);
    logic [10:0] observed;
    observed = {vgaIf.frameStart, vgaIf.hsync, vgaIf.vsync, vgaIf.r, vgaIf.g, vgaIf.b};
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s at cycle %0d: observed {fs,hs,vs,rgb}=%h expected=%h",
                tag, edgeCount, observed, expected);
  endtask

  function automatic logic [255:0] randomBoard();
    logic [255:0] bd;
    bd = '0;
    for (int n = 0; n < 64; n++) begin
      if ($urandom_range(0, 1) == 1) bd[n*4 +: 4] = 4'($urandom_range(0, 15));
    end
    return bd;
  endfunction

  function automatic logic [7:0] modelColour(input int x, input int y);
    int bx, by, col, row, ox, oy, sq, t;
    logic [3:0] nib;
    bit onBorder;
    if (x >= HA || y >= VA) return COL_BLANK;
    bx = x - X0;
    by = y - Y0;
    if (bx < 0 || by < 0 || bx >= 8 * S || by >= 8 * S) return COL_BACKGROUND;
    col = bx / S;
    row = by / S;
    ox  = bx % S;
    oy  = by % S;
    sq  = row * 8 + col;
    onBorder = (ox < BW) || (ox >= S - BW) || (oy < BW) || (oy >= S - BW);
    if (sq == int'(shCur) && onBorder) return COL_CURSOR;
    if (shEn && sq == int'(shSel) && onBorder) return COL_SELECT;
    nib = shBoard[sq*4 +: 4];
    t   = int'(nib[2:0]);
    if (t >= 1 && t <= 6 && ox >= INS && ox < S - INS && oy >= INS && oy < S - INS)
      return PIECE_PALETTE[nib[3]][nib[2:0]];
    return ((row + col) % 2 == 0) ? COL_LIGHT : COL_DARK;
  endfunction

  // e = CLK edges since reset release; pixel p reaches the pins on edge P*(p+2).
  function automatic logic [10:0] expectedOutputs(input int e);
    int p, q, x, y;
    logic fs, hs, vs;
    fs = 1'b0;
    if (e >= P && e % P == 0) begin
      q  = e / P - 1;
      fs = (q % HT == 0) && ((q / HT) % VT == VA);
    end
    if (e < 2 * P) return {fs, ~POL, ~POL, 8'h00};
    p  = e / P - 2;
    x  = p % HT;
    y  = (p / HT) % VT;
    hs = (x >= HA + HFP && x < HA + HFP + HSW) ? POL : ~POL;
    vs = (y >= VA + VFP && y < VA + VFP + VSW) ? POL : ~POL;
    return {fs, hs, vs, modelColour(x, y)};
  endfunction

  task automatic runCycles(input string tag, input int n);
    int q;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      edgeCount++;
      q = edgeCount / P - 1;
      if (edgeCount % P == 0 && q % HT == 0 && (q / HT) % VT == VA) begin
        shBoard = drvBoard;
        shCur   = drvCur;
        shSel   = drvSel;
        shEn    = drvEn;
      end
      @(negedge clk);
      checkOutput(tag, expectedOutputs(edgeCount));
    end
  endtask

  task automatic clearModel();
    edgeCount = 0;
    shBoard   = '0;
    shCur     = '0;
    shSel     = '0;
    shEn      = 1'b0;
  endtask

  initial begin
    logic [255:0] bd;
    logic [5:0]   cur;
    clearModel();
    applyStimulus('0, 6'd0, 6'd0, 1'b0);
    #2 rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("reset_values", RESET_OUT);
    end

    // Black king on square 0 with cursor and select both on it; first frame still shows the empty snapshot.
    bd = randomBoard();
    bd[3:0] = 4'b1110;
    applyStimulus(bd, 6'd0, 6'd0, 1'b1);
    rst = 1'b0;
    runCycles("first_frame_empty", FRAME_CYC);
    runCycles("king_cursor_select", FRAME_CYC);

    // Random game states changed at arbitrary points in the frame.
    for (int k = 0; k < 6; k++) begin
      cur = 6'($urandom_range(0, 63));
      applyStimulus(randomBoard(), cur,
                    ($urandom_range(0, 2) == 0) ? cur : 6'($urandom_range(0, 63)),
                    1'($urandom_range(0, 1)));
      runCycles("random_frame", $urandom_range(1000, 3000));
    end

    // Advance to an active pixel mid-frame, then reset asynchronously.
    for (int i = 0; i < FRAME_CYC + P; i++) begin
      if ((edgeCount / P - 2) % (HT * VT) == 20 * HT + 30) break;
      runCycles("to_reset_point", 1);
    end
    rst = 1'b1;
    #1 checkOutput("async_reset", RESET_OUT);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("held_reset", RESET_OUT);
    end
    clearModel();
    applyStimulus(randomBoard(), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1'b1);
    rst = 1'b0;
    runCycles("post_reset_frame", FRAME_CYC);
    applyStimulus(randomBoard(), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1'b1);
    runCycles("post_reset_next", FRAME_CYC);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
